ram_fifo_ctrl: RTL

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external 64x16 dual-port RAM with a 2-entry output buffer.
// Optional almost_full output when FIFO_ALMOST_FULL_EN is defined.
//
// Ports:
//   CLK, RST_n                          clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_data           producer side handshake
//   rd_valid/rd_ready/rd_data           consumer side handshake
//   count                               words accepted and not yet popped (0..2^AW)
//   ram_we/ram_en1/ram_addr1/ram_di     RAM write port
//   ram_en2/ram_addr2/ram_do2           RAM read port (registered address)
//   almost_full                         count >= AF_LEVEL (FIFO_ALMOST_FULL_EN only)
module ram_fifo_ctrl #(
  parameter int DW       = 16,
  parameter int AW       = 6,
  parameter int AF_LEVEL = 60
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          ram_we,
  output logic          ram_en1,
  output logic [AW-1:0] ram_addr1,
  output logic [DW-1:0] ram_di,
  output logic          ram_en2,
  output logic [AW-1:0] ram_addr2,
  input  logic [DW-1:0] ram_do2
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic          almost_full
`endif
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   unfetched;
  logic [1:0]    ob_cnt;
  logic          ob_head;
  logic          fetch_pend;
  logic [DW-1:0] ob_mem [2];

  logic          push;
  logic          pop;
  logic          issue;
  logic [2:0]    ob_sum;
  logic [2:0]    ob_lim;
  logic          ob_wr_idx;

  always_comb begin
    wr_ready  = RST_n & (count < DEPTH);
    rd_valid  = RST_n & (ob_cnt != 2'd0);
    push      = wr_valid & wr_ready;
    pop       = rd_valid & rd_ready;
    // Fetch only if the buffer can absorb it once the
    // pending word lands and this cycle's pop leaves.
    ob_sum    = {1'b0, ob_cnt} + {2'b0, fetch_pend};
    ob_lim    = 3'd1 + {2'b0, pop};
    issue     = RST_n & (unfetched != '0) & (ob_sum <= ob_lim);
    ob_wr_idx = ob_head ^ ob_cnt[0];
  end

  assign ram_en1   = push;
  assign ram_we    = push;
  assign ram_addr1 = wr_ptr;
  assign ram_di    = wr_data;
  assign ram_en2   = issue;
  assign ram_addr2 = rd_ptr;
  assign rd_data   = ob_mem[ob_head];

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      unfetched  <= '0;
      count      <= '0;
      ob_cnt     <= '0;
      ob_head    <= 1'b0;
      fetch_pend <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (issue)
        rd_ptr <= rd_ptr + 1'b1;
      unfetched  <= unfetched
                  + {{AW{1'b0}}, push}
                  - {{AW{1'b0}}, issue};
      count      <= count
                  + {{AW{1'b0}}, push}
                  - {{AW{1'b0}}, pop};
      ob_cnt     <= ob_cnt
                  + {1'b0, fetch_pend}
                  - {1'b0, pop};
      fetch_pend <= issue;
      if (pop)
        ob_head <= ~ob_head;
    end
  end

  // Capture lands behind the current head, so a
  // stalled rd_data never changes underneath.
  always_ff @(posedge CLK) begin
    if (fetch_pend)
      ob_mem[ob_wr_idx] <= ram_do2;
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [AW:0] AF_LVL = AF_LEVEL[AW:0];
  assign almost_full = RST_n & (count >= AF_LVL);
`endif

endmodule
